// File: rtl/multipli_seq_pkg.sv
// Shared types and constants for the sequential shift-add / Booth multiplier.
package multipli_seq_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand interpretation, sampled with A/B at the start edge
    localparam logic MODE_UNS = 1'b0;
    localparam logic MODE_SGN = 1'b1;

endpackage : multipli_seq_pkg

// File: rtl/multipli_step.sv
// One iteration of the multiplier datapath (purely combinational).
//   mode_i  : MODE_UNS = shift-add, MODE_SGN = radix-2 Booth
//   acc_i   : partial-product accumulator, A_BITS+1 bits
//   q_i     : multiplier shift register, B_BITS bits
//   qm1_i   : Booth history bit (previous Q[0])
//   m_i     : multiplicand, already sign/zero-extended to A_BITS+1
//   acc_o/q_o/qm1_o : register values after add/subtract and one right shift
module multipli_step
    import multipli_seq_pkg::*;
#(
    parameter int unsigned A_BITS = 8,
    parameter int unsigned B_BITS = 8
) (
    input  logic              mode_i,
    input  logic [A_BITS:0]   acc_i,
    input  logic [B_BITS-1:0] q_i,
    input  logic              qm1_i,
    input  logic [A_BITS:0]   m_i,
    output logic [A_BITS:0]   acc_o,
    output logic [B_BITS-1:0] q_o,
    output logic              qm1_o
);

    logic [A_BITS:0] sum;
    logic            shift_in;

    // Add/subtract selection, then a combined right shift of {ACC,Q,q_m1}
    always_comb begin
        sum = acc_i;
        if (mode_i == MODE_UNS) begin
            if (q_i[0]) begin
                sum = acc_i + m_i;
            end
        end else begin
            unique case ({q_i[0], qm1_i})
                2'b10:   sum = acc_i - m_i;
                2'b01:   sum = acc_i + m_i;
                default: sum = acc_i;
            endcase
        end

        // Unsigned sums never exceed A_BITS+1 bits, so a zero fill is exact;
        // Booth needs the sign replicated to keep the partial product signed.
        shift_in = (mode_i == MODE_SGN) ? sum[A_BITS] : 1'b0;
        acc_o    = {shift_in, sum[A_BITS:1]};
        q_o      = {sum[0], q_i[B_BITS-1:1]};
        qm1_o    = q_i[0];
    end

endmodule : multipli_step

// File: rtl/multipli_seq_param.sv
// Parametrised sequential multiplier: unsigned shift-add or signed Booth,
// one iteration per clock, B_BITS iterations per product.
//   CLOCK     : system clock, rising edge
//   RESET     : asynchronous active-low reset
//   START     : request, a new operation starts on a 0->1 transition in IDLE
//   SIGNED_OP : 0 unsigned operands, 1 two's-complement operands
//   A, B      : multiplicand / multiplier, captured at the start edge
//   S         : product, held until the next completion
//   END_MULT  : one-cycle pulse aligned with the S update
//   BUSY      : high while an operation is in progress
module multipli_seq_param
    import multipli_seq_pkg::*;
#(
    parameter int unsigned A_BITS = 8,
    parameter int unsigned B_BITS = 8,
    parameter int unsigned CNT_W  = $clog2(B_BITS + 1)
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     SIGNED_OP,
    input  logic [A_BITS-1:0]        A,
    input  logic [B_BITS-1:0]        B,
    output logic [A_BITS+B_BITS-1:0] S,
    output logic                     END_MULT,
    output logic                     BUSY
);

    localparam int unsigned P_BITS = A_BITS + B_BITS;

    state_t              state_q, state_d;
    logic                start_q;
    logic [A_BITS:0]     m_q, m_d;
    logic [A_BITS:0]     acc_q, acc_d;
    logic [B_BITS-1:0]   q_q, q_d;
    logic                qm1_q, qm1_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [P_BITS-1:0]   s_q, s_d;
    logic                end_q, end_d;
    logic                busy_q, busy_d;

    logic                trig;
    logic [A_BITS:0]     step_acc;
    logic [B_BITS-1:0]   step_q;
    logic                step_qm1;

    // Rising edge of START; only acted on in IDLE
    assign trig = START & ~start_q;

    multipli_step #(
        .A_BITS (A_BITS),
        .B_BITS (B_BITS)
    ) u_step (
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .q_i    (q_q),
        .qm1_i  (qm1_q),
        .m_i    (m_q),
        .acc_o  (step_acc),
        .q_o    (step_q),
        .qm1_o  (step_qm1)
    );

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        end_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    m_d     = (SIGNED_OP == MODE_SGN) ? {A[A_BITS-1], A} : {1'b0, A};
                    acc_d   = '0;
                    q_d     = B;
                    qm1_d   = 1'b0;
                    mode_d  = SIGNED_OP;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                qm1_d = step_qm1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(B_BITS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // ACC's top bit is only headroom; the product fits in A+B bits
                s_d     = {acc_q[A_BITS-1:0], q_q};
                end_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            mode_q  <= MODE_UNS;
            cnt_q   <= '0;
            s_q     <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= START;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    assign S        = s_q;
    assign END_MULT = end_q;
    assign BUSY     = busy_q;

endmodule : multipli_seq_param
